// File: rtl/fifo_drain_pkg.sv
// Shared types for the burst-gated FIFO read-side drain controller.
// Holds the drain FSM state encoding and the skid stage depth.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_BURST,
    DR_FLUSH
  } drain_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_drain_skid.sv
// skid_buffer: 2-entry registered valid/ready stage, strict FIFO order.
// Ports: in_valid/in_data/in_last capture, out_valid/out_ready/out_data/out_last, occ.
module skid_buffer
  import fifo_drain_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  T           in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output T           out_data,
  output logic       out_last,
  output logic [1:0] occ
);

  T           head_q, head_d;
  T           tail_q, tail_d;
  logic       hlast_q, hlast_d;
  logic       tlast_q, tlast_d;
  logic [1:0] occ_q, occ_d;
  logic       xfer;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign out_last  = hlast_q;
  assign occ       = occ_q;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    hlast_d = hlast_q;
    tlast_d = tlast_q;
    occ_d   = occ_q;
    unique case (occ_q)
      2'd0: begin
        if (in_valid) begin
          head_d  = in_data;
          hlast_d = in_last;
          occ_d   = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid && xfer) begin
          head_d  = in_data;
          hlast_d = in_last;
        end else if (in_valid) begin
          tail_d  = in_data;
          tlast_d = in_last;
          occ_d   = 2'd2;
        end else if (xfer) begin
          occ_d   = 2'd0;
        end
      end
      2'd2: begin
        // Full: a capture is only accepted alongside a transfer.
        if (xfer) begin
          head_d  = tail_q;
          hlast_d = tlast_q;
          if (in_valid) begin
            tail_d  = in_data;
            tlast_d = in_last;
          end else begin
            occ_d   = 2'd1;
          end
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= T'('0);
      tail_q  <= T'('0);
      hlast_q <= 1'b0;
      tlast_q <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      hlast_q <= hlast_d;
      tlast_q <= tlast_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: burst-gated FIFO read controller feeding a valid/ready stream.
// Ports: clk, rst_n, fifo_data/empty/count/pop, flush, m_valid/ready/data/last, busy;
// FIFO_DRAIN_PERF_EN adds stall_cycles and bursts_done.
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter type T         = logic [7:0],
  parameter int  DEPTH     = 8,
  parameter int  BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  T            fifo_data,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_count,
  output logic        fifo_pop,
  input  logic        flush,
  output logic        m_valid,
  input  logic        m_ready,
  output T            m_data,
  output logic        m_last,
  output logic        busy
`ifdef FIFO_DRAIN_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] bursts_done
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_e  state_q, state_d;
  logic [CW-1:0] beats_q, beats_d;
  logic          pend_q, pend_d;
  logic [1:0]    occ;

  // Pop depends only on registered state and fifo_empty, never m_ready.
  assign fifo_pop = (state_q != DR_IDLE)
                 && (beats_q != '0)
                 && !fifo_empty
                 && (occ < 2'(SKID_DEPTH));

  assign busy = (state_q != DR_IDLE) || (occ != 2'd0);

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    pend_d  = pend_q;
    unique case (state_q)
      DR_IDLE: begin
        if (pend_q && !fifo_empty) begin
          state_d = DR_FLUSH;
          beats_d = fifo_count[CW-1:0];
          pend_d  = 1'b0;
        end else if (fifo_count >= 32'(BURST_LEN)) begin
          state_d = DR_BURST;
          beats_d = CW'(BURST_LEN);
        end
      end
      DR_BURST, DR_FLUSH: begin
        if (beats_q == '0) begin
          state_d = DR_IDLE;
        end else if (fifo_pop) begin
          beats_d = beats_q - CW'(1);
        end
      end
      default: state_d = DR_IDLE;
    endcase
    if (flush) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DR_IDLE;
      beats_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      pend_q  <= pend_d;
    end
  end

  skid_buffer #(.T(T)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fifo_pop),
    .in_data  (fifo_data),
    .in_last  (beats_q == CW'(1)),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (m_data),
    .out_last (m_last),
    .occ      (occ)
  );

`ifdef FIFO_DRAIN_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] bursts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bursts_q <= '0;
    end else begin
      if (m_valid && !m_ready) begin
        stall_q <= stall_q + 32'd1;
      end
      if (m_valid && m_ready && m_last) begin
        bursts_q <= bursts_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign bursts_done  = bursts_q;
`endif

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Self-checking bench for fifo_burst_drain with a queue-based FIFO and
// transaction-level drain model; FIFO_DRAIN_PERF_EN enables counter checks.
module tb_fifo_burst_drain;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic [31:0] fifo_count;
  logic        fifo_pop;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
`ifdef FIFO_DRAIN_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] bursts_done;
`endif

  fifo_burst_drain #(
    .T(logic [7:0]), .DEPTH(8), .BURST_LEN(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_count(fifo_count),
    .fifo_pop  (fifo_pop),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
`ifdef FIFO_DRAIN_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .bursts_done (bursts_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  beat_t      exq[$];
  bit         m_act;
  int         rem, occ;
  bit         pend;
  int         pops, xfers, lasts, cyc;
  int         stalls_m, bursts_m;
  int         fx, lx;
  bit         prev_stall;
  logic [7:0] prev_d;
  logic       prev_l;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_count = 32'(fq.size());
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic grant(int n);
    beat_t b;
    m_act = 1'b1;
    rem   = n;
    for (int i = 0; i < n; i++) begin
      b.d = fq[i];
      b.l = (i == n - 1);
      exq.push_back(b);
    end
  endtask

  task automatic model_reset();
    exq.delete();
    m_act = 0; rem = 0; occ = 0; pend = 0;
    stalls_m = 0; bursts_m = 0; prev_stall = 0;
  endtask

  // One clock: entered and left at posedge+1.
  task automatic tick(bit push, logic [7:0] pd, bit fl, bit rdy);
    logic s_pop, s_v, s_l;
    logic [7:0] s_d;
    bit exp_pop, xfer;
    beat_t b;
    m_ready = rdy;
    flush   = fl;
    @(negedge clk);
    s_pop = fifo_pop; s_v = m_valid; s_d = m_data; s_l = m_last;
    exp_pop = m_act && rem > 0 && fq.size() > 0 && occ < 2;
    check("pop", 32'(s_pop), 32'(exp_pop));
    check("valid", 32'(s_v), 32'(occ > 0));
    if (prev_stall) begin
      check("stable_data", 32'(s_d), 32'(prev_d));
      check("stable_last", 32'(s_l), 32'(prev_l));
    end
    xfer = s_v && rdy;
    if (xfer) begin
      if (exq.size() == 0) begin
        check("extra_beat", 32'(1), 32'(0));
      end else begin
        b = exq.pop_front();
        check("data", 32'(s_d), 32'(b.d));
        check("last", 32'(s_l), 32'(b.l));
      end
      if (s_l) begin lasts++; bursts_m++; end
      lx = cyc;
      xfers++;
    end
    if (s_v && !rdy) stalls_m++;
    prev_stall = s_v && !rdy;
    prev_d = s_d; prev_l = s_l;
    if (!m_act) begin
      if (pend && fq.size() > 0) begin
        grant(fq.size());
        pend = 0;
      end else if (fq.size() >= 4) begin
        grant(4);
      end
    end else if (rem == 0) begin
      m_act = 0;
    end else if (s_pop) begin
      rem--;
    end
    if (fl) pend = 1;
    if (s_pop) begin
      void'(fq.pop_front());
      pops++;
      occ++;
    end
    if (xfer) occ--;
    @(posedge clk);
    #1;
    cyc++;
    if (push && fq.size() < 8) fq.push_back(pd);
    refresh();
  endtask

  int pm, xm, lm;
  bit done;

  initial begin
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    pops = 0; xfers = 0; lasts = 0; cyc = 0; fx = 0; lx = 0;
    model_reset();
    refresh();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_valid), 32'(0));
    check("rst_data", 32'(m_data), 32'(0));
    check("rst_last", 32'(m_last), 32'(0));
    check("rst_pop", 32'(fifo_pop), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: below threshold, then a full burst
    pm = pops;
    for (int i = 0; i < 3; i++) tick(1, 8'h10 + 8'(i), 0, 1);
    repeat (4) tick(0, 8'h00, 0, 1);
    check("t1_nopop", 32'(pops - pm), 32'(0));
    check("t1_novalid", 32'(m_valid), 32'(0));
    xm = xfers; lm = lasts;
    tick(1, 8'h13, 0, 1);
    fx = -1;
    for (int i = 0; i < 8; i++) begin
      tick(0, 8'h00, 0, 1);
      if (fx < 0 && xfers != xm) fx = lx;
    end
    check("t1_beats", 32'(xfers - xm), 32'(4));
    check("t1_lasts", 32'(lasts - lm), 32'(1));
    check("t1_consec", 32'(lx - fx), 32'(3));
    check("t1_idle", 32'(busy), 32'(0));

    // 2: back-pressure limits pops to the skid depth
    pm = pops; xm = xfers;
    for (int i = 0; i < 4; i++) tick(1, 8'hA0 + 8'(i), 0, 0);
    repeat (6) tick(0, 8'h00, 0, 0);
    check("t2_pops", 32'(pops - pm), 32'(2));
    check("t2_count", fifo_count, 32'(2));
    repeat (8) tick(0, 8'h00, 0, 1);
    check("t2_beats", 32'(xfers - xm), 32'(4));

    // 3: flush drains only the snapshot
    xm = xfers; lm = lasts;
    tick(1, 8'h21, 0, 1);
    tick(1, 8'h22, 0, 1);
    tick(0, 8'h00, 1, 1);
    tick(1, 8'h31, 0, 1);
    tick(1, 8'h32, 0, 1);
    repeat (5) tick(0, 8'h00, 0, 1);
    check("t3_beats", 32'(xfers - xm), 32'(2));
    check("t3_lasts", 32'(lasts - lm), 32'(1));
    check("t3_left", fifo_count, 32'(2));
    xm = xfers;
    tick(0, 8'h00, 1, 1);
    repeat (6) tick(0, 8'h00, 0, 1);
    check("t3_rest", 32'(xfers - xm), 32'(2));

    // 4: flush on empty stays pending
    xm = xfers; lm = lasts;
    tick(0, 8'h00, 1, 1);
    repeat (5) tick(0, 8'h00, 0, 1);
    check("t4_busy", 32'(busy), 32'(0));
    check("t4_none", 32'(xfers - xm), 32'(0));
    tick(1, 8'h44, 0, 1);
    repeat (5) tick(0, 8'h00, 0, 1);
    check("t4_beats", 32'(xfers - xm), 32'(1));
    check("t4_lasts", 32'(lasts - lm), 32'(1));

    // 5: reset mid-burst with a full skid
    for (int i = 0; i < 4; i++) tick(1, 8'h50 + 8'(i), 0, 0);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick(0, 8'h00, 0, 0);
      done = (occ == 2);
    end
    check("t5_full", 32'(done), 32'(1));
    check("t5_busy", 32'(busy), 32'(1));
`ifdef FIFO_DRAIN_PERF_EN
    check("perf_stall_a", stall_cycles, 32'(stalls_m));
    check("perf_burst_a", 32'(bursts_done), 32'(bursts_m));
`endif
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(m_valid), 32'(0));
    check("t5_busy0", 32'(busy), 32'(0));
    check("t5_pop", 32'(fifo_pop), 32'(0));
    check("t5_fifo", fifo_count, 32'(2));
`ifdef FIFO_DRAIN_PERF_EN
    check("perf_rst", stall_cycles, 32'(0));
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    refresh();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 1) == 1), 8'($urandom()),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0));
    end
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick(0, 8'h00, 1, 1);
      done = fq.size() == 0 && exq.size() == 0 && !m_act && occ == 0;
    end
    check("drain_done", 32'(done), 32'(1));
    check("final_busy", 32'(busy), 32'(0));
    check("final_exq", 32'(exq.size()), 32'(0));
`ifdef FIFO_DRAIN_PERF_EN
    check("perf_stall", stall_cycles, 32'(stalls_m));
    check("perf_burst", 32'(bursts_done), 32'(bursts_m));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
